// File: rtl/sram_fetch_ctrl.sv
// sram_fetch_ctrl
//   Read sequencer in front of a synchronous-read coefficient ROM (1-cycle
//   read latency). On an accepted start it reads len consecutive words from
//   address 0 and presents them in address order on a valid/ready stream.
//   A small circular buffer absorbs the read latency so that downstream
//   backpressure never drops a word.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle job request, only looked at while idle
//   len        words to fetch (0 legal, values above 2^ADDR_WIDTH are clamped)
//   sram_addr  ROM read address (holds while sram_en is low)
//   sram_en    ROM read enable
//   sram_dout  ROM read data, valid the cycle after sram_en
//   out_data   head-of-buffer word (0 while the buffer is empty)
//   out_valid  out_data valid
//   out_ready  downstream accept
//   busy       job in progress, from the cycle after start through done
//   done       1-cycle pulse after the last word has transferred
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | issuing reads while words remain and the buffer has room
// DRAIN  | all reads issued; waiting for the buffer to empty
// DONE   | one-cycle completion pulse
module sram_fetch_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_en,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int LW  = ADDR_WIDTH + 1;
  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW  = $clog2(BUF_DEPTH + 1);
  localparam int OW1 = OW + 1;
  localparam logic [LW-1:0]  MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]  LAST_IDX = PW'(BUF_DEPTH - 1);
  localparam logic [OW1-1:0] DEPTH_W  = OW1'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_nx;
  logic [LW-1:0]         rem_q, rem_nx, len_clamped;
  logic [LW-1:0]         cnt_q, cnt_base;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  en_q, en_d, en_d1_q;
  logic [OW-1:0]         occ_q, occ_nx;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // A read issued last cycle has its data on sram_dout now; it lands in the
  // buffer at the end of this cycle.
  assign push        = en_d1_q;
  assign pop         = out_valid && out_ready;
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign cnt_base    = (state_q == S_IDLE) ? '0 : cnt_q;

  always_comb begin
    state_nx = state_q;
    rem_nx   = rem_q;
    occ_nx   = occ_q + OW'(push) - OW'(pop);
    en_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_nx   = len_clamped;
          state_nx = (len_clamped == '0) ? S_DRAIN : S_FETCH;
        end
      end
      S_FETCH: begin
        rem_nx = rem_q - {{ADDR_WIDTH{1'b0}}, en_q};
        if (rem_nx == '0) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // No reads are outstanding here except the one captured this cycle,
        // which occ_nx already includes.
        if (occ_nx == '0) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // sram_en is a flop, so next cycle's issue is decided from next-cycle
    // occupancy plus the read issued this cycle (still in flight then).
    en_d = (state_nx == S_FETCH) && (rem_nx != '0) &&
           (({1'b0, occ_nx} + OW1'(en_q)) < DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      en_d1_q  <= 1'b0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_nx;
      rem_q   <= rem_nx;
      occ_q   <= occ_nx;
      en_q    <= en_d;
      en_d1_q <= en_q;
      if (en_d) begin
        addr_q <= cnt_base[ADDR_WIDTH-1:0];
        cnt_q  <= cnt_base + 1'b1;
      end else begin
        cnt_q  <= cnt_base;
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= sram_dout;
  end

  assign sram_en   = en_q;
  assign sram_addr = addr_q;
  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sram_fetch_ctrl.sv
module tb_sram_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic [3:0] sram_addr;
  logic       sram_en;
  logic [7:0] sram_dout = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [16];
  logic [7:0] exp4 [4] = '{8'd1, 8'd6, 8'd5, 8'd0};

  logic       tr_en [32], tr_valid [32], tr_done [32], tr_busy [32];
  logic [3:0] tr_addr [32];
  logic [7:0] tr_data [32];

  bit         mon_on = 1'b0;
  logic [7:0] xq [$];
  logic [3:0] aq [$];
  int         done_cnt = 0;
  int         max_out = 0;

  sram_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_dout(sram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_en) sram_dout <= ram[sram_addr];

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (sram_en) aq.push_back(sram_addr);
      if (aq.size() - xq.size() > max_out) max_out = aq.size() - xq.size();
      if (out_valid && out_ready) xq.push_back(out_data);
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mon_clear();
    xq.delete();
    aq.delete();
    done_cnt = 0;
    max_out  = 0;
  endtask

  // Start pulse in cycle 0; returns 1 time unit into cycle 1.
  task automatic pulse_start(input logic [4:0] l);
    @(posedge clk); #1 start = 1'b1; len = l;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_trace(input int n, input int rdy_from);
    for (int c = 1; c <= n; c++) begin
      out_ready = (c >= rdy_from);
      @(negedge clk);
      tr_en[c] = sram_en;  tr_addr[c] = sram_addr;
      tr_valid[c] = out_valid; tr_data[c] = out_data;
      tr_done[c] = done; tr_busy[c] = busy;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_job(input logic [4:0] l, input bit rnd, input int restart_at);
    bit seen = 1'b0;
    mon_clear();
    mon_on = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    pulse_start(l);
    for (int c = 1; c < 400 && !seen; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == restart_at) begin start = 1'b1; len = 5'd9; end
      else start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL job_timeout len=%0d got no done, exp done", l); end
    repeat (2) @(posedge clk);
    #1 mon_on = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (sram_en !== 1'b0)   begin errors++; $display("FAIL rst_en got %b exp 0", sram_en); end
    if (sram_addr !== 4'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", sram_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    if (out_data !== 8'd0)  begin errors++; $display("FAIL rst_data got %0h exp 0", out_data); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    pulse_start(5'd4);
    run_trace(10, 1);
    for (int c = 1; c <= 10; c++) begin
      logic e_en, e_val;
      e_en  = (c <= 4);
      e_val = (c >= 3 && c <= 6);
      checks += 4;
      if (tr_en[c] !== e_en) begin errors++; $display("FAIL basic_en c=%0d got %b exp %b", c, tr_en[c], e_en); end
      if (tr_valid[c] !== e_val) begin errors++; $display("FAIL basic_valid c=%0d got %b exp %b", c, tr_valid[c], e_val); end
      if (tr_done[c] !== (c == 7)) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, tr_done[c], c == 7); end
      if (tr_busy[c] !== (c <= 7)) begin errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, tr_busy[c], c <= 7); end
      if (e_en) begin
        checks++;
        if (tr_addr[c] !== 4'(c - 1)) begin errors++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, tr_addr[c], c - 1); end
      end
      if (e_val) begin
        checks++;
        if (tr_data[c] !== exp4[c-3]) begin errors++; $display("FAIL basic_data c=%0d got %0d exp %0d", c, tr_data[c], exp4[c-3]); end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    pulse_start(5'd4);
    run_trace(16, 10);
    for (int c = 1; c <= 16; c++) begin
      logic e_val;
      int   idx;
      e_val = (c >= 3 && c <= 13);
      idx   = (c < 10) ? 0 : c - 10;
      checks += 3;
      if (tr_en[c] !== (c <= 4)) begin errors++; $display("FAIL bp_en c=%0d got %b exp %b", c, tr_en[c], c <= 4); end
      if (tr_valid[c] !== e_val) begin errors++; $display("FAIL bp_valid c=%0d got %b exp %b", c, tr_valid[c], e_val); end
      if (tr_done[c] !== (c == 14)) begin errors++; $display("FAIL bp_done c=%0d got %b exp %b", c, tr_done[c], c == 14); end
      if (e_val) begin
        checks++;
        if (tr_data[c] !== exp4[idx]) begin errors++; $display("FAIL bp_data c=%0d got %0d exp %0d", c, tr_data[c], exp4[idx]); end
      end
    end
  endtask

  task automatic test_len0();
    out_ready = 1'b1;
    pulse_start(5'd0);
    run_trace(5, 1);
    for (int c = 1; c <= 5; c++) begin
      checks += 4;
      if (tr_en[c] !== 1'b0) begin errors++; $display("FAIL len0_en c=%0d got %b exp 0", c, tr_en[c]); end
      if (tr_valid[c] !== 1'b0) begin errors++; $display("FAIL len0_valid c=%0d got %b exp 0", c, tr_valid[c]); end
      if (tr_busy[c] !== (c <= 2)) begin errors++; $display("FAIL len0_busy c=%0d got %b exp %b", c, tr_busy[c], c <= 2); end
      if (tr_done[c] !== (c == 2)) begin errors++; $display("FAIL len0_done c=%0d got %b exp %b", c, tr_done[c], c == 2); end
    end
  endtask

  task automatic test_random_ready();
    run_job(5'd9, 1'b1, 0);
    checks += 3;
    if (xq.size() != 9) begin errors++; $display("FAIL rnd_count got %0d exp 9", xq.size()); end
    if (max_out > 4) begin errors++; $display("FAIL rnd_occupancy got %0d exp <=4", max_out); end
    if (done_cnt != 1) begin errors++; $display("FAIL rnd_done_cnt got %0d exp 1", done_cnt); end
    for (int i = 0; i < xq.size() && i < 9; i++) begin
      checks++;
      if (xq[i] !== ram[i]) begin errors++; $display("FAIL rnd_data i=%0d got %0h exp %0h", i, xq[i], ram[i]); end
    end
    for (int i = 0; i < aq.size() && i < 9; i++) begin
      checks++;
      if (aq[i] !== 4'(i)) begin errors++; $display("FAIL rnd_addr i=%0d got %0d exp %0d", i, aq[i], i); end
    end
  endtask

  task automatic test_restart_ignored();
    run_job(5'd4, 1'b0, 2);
    checks += 3;
    if (xq.size() != 4) begin errors++; $display("FAIL restart_count got %0d exp 4", xq.size()); end
    if (aq.size() != 4) begin errors++; $display("FAIL restart_issues got %0d exp 4", aq.size()); end
    if (done_cnt != 1) begin errors++; $display("FAIL restart_done_cnt got %0d exp 1", done_cnt); end
    for (int i = 0; i < xq.size() && i < 4; i++) begin
      checks++;
      if (xq[i] !== exp4[i]) begin errors++; $display("FAIL restart_data i=%0d got %0d exp %0d", i, xq[i], exp4[i]); end
    end
  endtask

  task automatic test_clamp();
    run_job(5'd20, 1'b0, 0);
    checks += 2;
    if (xq.size() != 16) begin errors++; $display("FAIL clamp_count got %0d exp 16", xq.size()); end
    if (done_cnt != 1) begin errors++; $display("FAIL clamp_done_cnt got %0d exp 1", done_cnt); end
    for (int i = 0; i < xq.size() && i < 16; i++) begin
      checks += 2;
      if (xq[i] !== ram[i]) begin errors++; $display("FAIL clamp_data i=%0d got %0h exp %0h", i, xq[i], ram[i]); end
      if (aq[i] !== 4'(i)) begin errors++; $display("FAIL clamp_addr i=%0d got %0d exp %0d", i, aq[i], i); end
    end
  endtask

  task automatic test_reset_midfetch();
    out_ready = 1'b1;
    pulse_start(5'd9);
    repeat (3) begin @(posedge clk); #1; end
    // cycle 4: read of address 3 issuing, word 6 at the head
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    if (sram_addr !== 4'd3) begin errors++; $display("FAIL mid_pre_addr got %0d exp 3", sram_addr); end
    if (out_data !== 8'd6)  begin errors++; $display("FAIL mid_pre_data got %0d exp 6", out_data); end
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (sram_en !== 1'b0)   begin errors++; $display("FAIL mid_rst_en got %b exp 0", sram_en); end
    if (sram_addr !== 4'd0) begin errors++; $display("FAIL mid_rst_addr got %0d exp 0", sram_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    if (out_data !== 8'd0)  begin errors++; $display("FAIL mid_rst_data got %0h exp 0", out_data); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL mid_rst_done got %b exp 0", done); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(5'd2, 1'b0, 0);
    checks += 2;
    if (xq.size() != 2) begin errors++; $display("FAIL post_rst_count got %0d exp 2", xq.size()); end
    if (done_cnt != 1)  begin errors++; $display("FAIL post_rst_done_cnt got %0d exp 1", done_cnt); end
    for (int i = 0; i < xq.size() && i < 2; i++) begin
      checks++;
      if (xq[i] !== exp4[i]) begin errors++; $display("FAIL post_rst_data i=%0d got %0d exp %0d", i, xq[i], exp4[i]); end
    end
  endtask

  initial begin
    ram[0] = 8'd1; ram[1] = 8'd6; ram[2] = 8'd5; ram[3] = 8'd0;
    for (int i = 4; i < 16; i++) ram[i] = 8'(8'h10 + i);
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_random_ready();
    test_restart_ignored();
    test_clamp();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
